instruction_fetch_stage: RTL and testbench

- Fetch stage of the MIPS pipeline; sits directly upstream of the instruction memory.
- Owns the program counter and drives the word index into the instruction memory.
- Captures the returned instruction into the IF/ID pipeline register along with PC+4.
- Handles stall, branch/jump redirect with squash, and a halt state.

---
 rtl/instruction_fetch_stage.sv | 141 ++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// MIPS instruction fetch stage: owns the PC, drives the instruction memory word index and fills IF/ID.
// Optional FETCH_PERF_CNT_EN adds saturating FetchCount/StallCount outputs.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 10
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Stall,
  input  logic                   BranchTaken,
  input  logic [31:0]            BranchTarget,
  input  logic                   Jump,
  input  logic [31:0]            JumpTarget,
  input  logic                   HaltReq,
  output logic [IMEM_ADDR_W-1:0] IMemAddress,
  input  logic [31:0]            IMemInstruction,
  output logic [31:0]            PC,
  output logic [31:0]            IF_ID_Instruction,
  output logic [31:0]            IF_ID_PCPlus4,
  output logic                   IF_ID_Valid,
  output logic                   Halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            FetchCount,
  output logic [31:0]            StallCount
`endif
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        run_fetch;
  logic        run_stall;

  assign pc_plus4  = pc_q + 32'd4;
  assign redirect  = Jump | BranchTaken;
  assign run_fetch = (state_q == S_RUN) && !HaltReq && !redirect && !Stall;
  assign run_stall = (state_q == S_RUN) && !HaltReq && !redirect && Stall;

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through the case infers a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pcp4_d   = pcp4_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    unique case (state_q)
      S_BOOT: begin
        instr_d = 32'd0;
        pcp4_d  = 32'd0;
        valid_d = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (HaltReq) begin
          instr_d  = 32'd0;
          pcp4_d   = 32'd0;
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (redirect) begin
          // Jump beats branch; the wrong-path fetch sitting at PC is squashed.
          pc_d    = Jump ? (JumpTarget & ~32'd3) : (BranchTarget & ~32'd3);
          instr_d = 32'd0;
          pcp4_d  = 32'd0;
          valid_d = 1'b0;
        end else if (!Stall) begin
          pc_d    = pc_plus4;
          instr_d = IMemInstruction;
          pcp4_d  = pc_plus4;
          valid_d = 1'b1;
        end
      end
      S_HALT: ;
      default: state_d = S_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      pcp4_q   <= 32'd0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcp4_q   <= pcp4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign IMemAddress       = pc_q[IMEM_ADDR_W+1:2];
  assign PC                = pc_q;
  assign IF_ID_Instruction = instr_q;
  assign IF_ID_PCPlus4     = pcp4_q;
  assign IF_ID_Valid       = valid_q;
  assign Halted            = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (run_fetch && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (run_stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FetchCount = fetch_cnt_q;
  assign StallCount = stall_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = run_fetch ^ run_stall;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: a behavioural model queues expected IF state per cycle.
// A second instance with RESET_PC=FFFF_FFF8 covers PC wrap and the IMemAddress slice.
module tb_instruction_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall, br, jmp, halt_req;
  logic [31:0] br_tgt, jmp_tgt;
  logic [9:0]  imem_addr, imem_addr2;
  logic [31:0] imem_instr, imem_instr2;
  logic [31:0] pc, if_instr, if_pcp4, pc2, if_instr2, if_pcp42;
  logic        if_valid, halted, if_valid2, halted2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, fetch_cnt2, stall_cnt2;
`endif

  int n_total = 0;
  int n_bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
    logic        halted;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } exp_t;

  exp_t exp_q[$];

  // model state
  logic [31:0] m_pc, m_ins, m_p4, m_fc, m_sc;
  logic        m_v, m_h;
  int          m_st;  // 0 boot, 1 run, 2 halt

  // word i of memory holds i*4
  assign imem_instr  = {20'd0, imem_addr, 2'b00};
  assign imem_instr2 = {20'd0, imem_addr2, 2'b00};

  instruction_fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_W(10)) dut (
    .Clk(clk), .Rst(rst), .Stall(stall), .BranchTaken(br), .BranchTarget(br_tgt),
    .Jump(jmp), .JumpTarget(jmp_tgt), .HaltReq(halt_req), .IMemAddress(imem_addr),
    .IMemInstruction(imem_instr), .PC(pc), .IF_ID_Instruction(if_instr),
    .IF_ID_PCPlus4(if_pcp4), .IF_ID_Valid(if_valid), .Halted(halted)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount(fetch_cnt), .StallCount(stall_cnt)
`endif
  );

  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .IMEM_ADDR_W(10)) dut_wrap (
    .Clk(clk), .Rst(rst), .Stall(stall), .BranchTaken(br), .BranchTarget(br_tgt),
    .Jump(jmp), .JumpTarget(jmp_tgt), .HaltReq(halt_req), .IMemAddress(imem_addr2),
    .IMemInstruction(imem_instr2), .PC(pc2), .IF_ID_Instruction(if_instr2),
    .IF_ID_PCPlus4(if_pcp42), .IF_ID_Valid(if_valid2), .Halted(halted2)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount(fetch_cnt2), .StallCount(stall_cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Advance the model one posedge using the inputs currently driven.
  task automatic model_step();
    logic [31:0] mem_word;
    mem_word = {20'd0, m_pc[11:2], 2'b00};
    if (!rst) begin
      m_pc = 32'h0; m_ins = 0; m_p4 = 0; m_v = 0; m_h = 0; m_st = 0; m_fc = 0; m_sc = 0;
    end else if (m_st == 0) begin
      m_ins = 0; m_p4 = 0; m_v = 0; m_st = 1;
    end else if (m_st == 1) begin
      if (halt_req) begin
        m_ins = 0; m_p4 = 0; m_v = 0; m_h = 1; m_st = 2;
      end else if (jmp) begin
        m_pc = {jmp_tgt[31:2], 2'b00}; m_ins = 0; m_p4 = 0; m_v = 0;
      end else if (br) begin
        m_pc = {br_tgt[31:2], 2'b00}; m_ins = 0; m_p4 = 0; m_v = 0;
      end else if (stall) begin
        if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      end else begin
        m_ins = mem_word; m_p4 = m_pc + 4; m_pc = m_pc + 4; m_v = 1;
        if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt, input logic h);
    exp_t e;
    exp_t g;
    rst = r; stall = s; br = b; br_tgt = bt; jmp = j; jmp_tgt = jt; halt_req = h;
    model_step();
    e = '{pc: m_pc, instr: m_ins, pcp4: m_p4, valid: m_v, halted: m_h, fcnt: m_fc, scnt: m_sc};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    check("sb_pc", pc, g.pc);
    check("sb_instr", if_instr, g.instr);
    check("sb_pcp4", if_pcp4, g.pcp4);
    check("sb_valid", {31'd0, if_valid}, {31'd0, g.valid});
    check("sb_halted", {31'd0, halted}, {31'd0, g.halted});
    check("sb_imem_addr", {22'd0, imem_addr}, {22'd0, g.pc[11:2]});
`ifdef FETCH_PERF_CNT_EN
    check("sb_fetch_cnt", fetch_cnt, g.fcnt);
    check("sb_stall_cnt", stall_cnt, g.scnt);
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 0; stall = 0; br = 0; jmp = 0; halt_req = 0; br_tgt = 0; jmp_tgt = 0;
    m_pc = 0; m_ins = 0; m_p4 = 0; m_v = 0; m_h = 0; m_st = 0; m_fc = 0; m_sc = 0;
    #2;

    // reset then run
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    run(1);
    check("boot_pc", pc, 32'h0);
    check("boot_valid", {31'd0, if_valid}, 32'd0);
    run(1);
    check("first_valid", {31'd0, if_valid}, 32'd1);
    check("first_instr", if_instr, 32'h0);
    check("first_pcp4", if_pcp4, 32'h4);
    run(1);
    check("pc_8", pc, 32'h8);

    // stall at PC=8
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0, 0, 0);
      check("stall_pc", pc, 32'h8);
      check("stall_instr", if_instr, 32'h4);
      check("stall_pcp4", if_pcp4, 32'h8);
    end
    run(1);
    check("unstall_pc", pc, 32'hC);
    check("unstall_instr", if_instr, 32'h8);

    // redirect overrides stall
    step(1, 1, 1, 32'h40, 0, 0, 0);
    check("br_pc", pc, 32'h40);
    check("br_squash", {31'd0, if_valid}, 32'd0);
    run(1);
    check("br_pcp4", if_pcp4, 32'h44);
    step(1, 0, 1, 32'h40, 1, 32'h81, 0);
    check("jmp_wins_pc", pc, 32'h80);
    check("jmp_squash", {31'd0, if_valid}, 32'd0);
    run(2);

    // halt outranks jump, then holds against everything but reset
    step(1, 0, 0, 0, 1, 32'h20, 0);
    check("pre_halt_pc", pc, 32'h20);
    step(1, 0, 0, 0, 1, 32'h100, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom, 1);
      check("halt_pc", pc, 32'h20);
      check("halt_flag", {31'd0, halted}, 32'd1);
      check("halt_valid", {31'd0, if_valid}, 32'd0);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    check("halt_rst_pc", pc, 32'h0);
    check("halt_rst_flag", {31'd0, halted}, 32'd0);

    // reset during a redirect
    run(2);
    step(0, 1, 1, 32'h300, 1, 32'h200, 0);
    check("rst_redir_pc", pc, 32'h0);
    check("rst_redir_valid", {31'd0, if_valid}, 32'd0);

    // wrap on the second instance
    check("wrap_pc0", pc2, 32'hFFFF_FFF8);
    check("wrap_addr0", {22'd0, imem_addr2}, 32'h3FE);
    run(1);
    check("wrap_pc1", pc2, 32'hFFFF_FFF8);
    run(1);
    check("wrap_pc2", pc2, 32'hFFFF_FFFC);
    check("wrap_addr2", {22'd0, imem_addr2}, 32'h3FF);
    run(1);
    check("wrap_pc3", pc2, 32'h0);
    check("wrap_addr3", {22'd0, imem_addr2}, 32'h0);
    check("wrap_pcp4", if_pcp42, 32'h0);

`ifdef FETCH_PERF_CNT_EN
    step(0, 0, 0, 0, 0, 0, 0);
    run(6);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 32'h40, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0);
    check("perf_fetch", fetch_cnt, 32'd5);
    check("perf_stall", stall_cnt, 32'd3);
`endif

    // randomized scoreboard run
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           $urandom, ($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 29) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
